// File: rtl/xilinx_rst_seq.sv
// Reset sequencer between the clock wizard / board button / VIO and the
// Cheshire SoC. Synchronizes and debounces the reset sources, holds the SoC
// in reset for HoldCycles after all sources go quiet, releases the SoC, then
// releases USB UsbDelayCycles later. Boot-mode switches are captured at the
// SoC release point and the cause of the last reset is reported.
module xilinx_rst_seq #(
  parameter int HoldCycles     = 64,
  parameter int UsbDelayCycles = 16,
  parameter int DebounceCycles = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       locked_i,
  input  logic       btn_rst_i,
  input  logic       vio_rst_i,
  input  logic       test_mode_i,
  input  logic [1:0] boot_mode_i,
  output logic       soc_rst_no,
  output logic       usb_rst_no,
  output logic [1:0] boot_mode_o,
  output logic [1:0] rst_cause_o,
  output logic       busy_o
);

  localparam int MaxHU     = (HoldCycles > UsbDelayCycles) ? HoldCycles : UsbDelayCycles;
  localparam int MaxCycles = (MaxHU > DebounceCycles) ? MaxHU : DebounceCycles;
  localparam int CntW      = $clog2(MaxCycles) + 1;

  localparam logic [1:0] CauseBtn  = 2'd1;
  localparam logic [1:0] CauseVio  = 2'd2;
  localparam logic [1:0] CauseLock = 2'd3;

  typedef enum logic [1:0] {WAIT_SRC, HOLD, USB_WAIT, RUN} state_e;

  logic            locked_meta_q, locked_sync_q;
  logic            btn_meta_q, btn_sync_q;
  logic [CntW-1:0] db_cnt_q, db_cnt_d;
  logic            btn_db_q, btn_db_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            soc_q, soc_d;
  logic            usb_q, usb_d;
  logic [1:0]      boot_q, boot_d;
  logic [1:0]      cause_q, cause_d;
  logic            busy_q, busy_d;
  logic            src_act;
  logic [1:0]      cause_now;

  // Two-flop synchronizers for the asynchronous lock and button inputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_meta_q <= 1'b0;
      locked_sync_q <= 1'b0;
      btn_meta_q    <= 1'b0;
      btn_sync_q    <= 1'b0;
    end else begin
      locked_meta_q <= locked_i;
      locked_sync_q <= locked_meta_q;
      btn_meta_q    <= btn_rst_i;
      btn_sync_q    <= btn_meta_q;
    end
  end

  // Debouncer: flip the filtered button only after DebounceCycles of disagreement
  always_comb begin
    db_cnt_d = db_cnt_q;
    btn_db_d = btn_db_q;
    if (btn_sync_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == CntW'(DebounceCycles - 1)) begin
      btn_db_d = ~btn_db_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + CntW'(1);
    end
  end

  // Debouncer state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt_q <= '0;
      btn_db_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      btn_db_q <= btn_db_d;
    end
  end

  // Any source holding the SoC in reset; lock loss outranks button outranks VIO
  always_comb begin
    src_act = ~locked_sync_q | btn_db_q | vio_rst_i;
    if (!locked_sync_q) begin
      cause_now = CauseLock;
    end else if (btn_db_q) begin
      cause_now = CauseBtn;
    end else begin
      cause_now = CauseVio;
    end
  end

  // FSM state and sequencing counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAIT_SRC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter clears on every terminal value so it never wraps
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_SRC: begin
        if (!src_act) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (src_act) begin
          state_d = WAIT_SRC;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(HoldCycles - 1)) begin
          state_d = USB_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      USB_WAIT: begin
        if (src_act) begin
          state_d = WAIT_SRC;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(UsbDelayCycles - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RUN: begin
        if (src_act) begin
          state_d = WAIT_SRC;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_SRC;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values, derived from the transition taken on this edge
  always_comb begin
    soc_d   = soc_q;
    usb_d   = usb_q;
    boot_d  = boot_q;
    cause_d = cause_q;
    busy_d  = busy_q;
    if (state_q != WAIT_SRC && state_d == WAIT_SRC) begin
      soc_d   = 1'b0;
      usb_d   = 1'b0;
      busy_d  = 1'b1;
      cause_d = cause_now;
    end
    if (state_q == HOLD && state_d == USB_WAIT) begin
      soc_d  = 1'b1;
      boot_d = boot_mode_i;
    end
    if (state_q == USB_WAIT && state_d == RUN) begin
      usb_d  = 1'b1;
      busy_d = 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      soc_q   <= 1'b0;
      usb_q   <= 1'b0;
      boot_q  <= 2'b00;
      cause_q <= 2'b00;
      busy_q  <= 1'b1;
    end else begin
      soc_q   <= soc_d;
      usb_q   <= usb_d;
      boot_q  <= boot_d;
      cause_q <= cause_d;
      busy_q  <= busy_d;
    end
  end

  // Test mode hands the reset outputs straight to the board reset
  assign soc_rst_no  = test_mode_i ? rst_ni : soc_q;
  assign usb_rst_no  = test_mode_i ? rst_ni : usb_q;
  assign boot_mode_o = boot_q;
  assign rst_cause_o = cause_q;
  assign busy_o      = busy_q;

endmodule
